// File: rtl/rca_4bit_adder_if.sv
// Operand/result bundle for the registered 4-bit ripple-carry adder.
// The master drives operands and observes results; the slave is the adder itself.
interface rca_4bit_adder_if;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic       ci;
  logic [3:0] s;
  logic       co;
  logic       ovf;
  logic       out_valid;

  modport master (
    output in_valid, x, y, ci,
    input  s, co, ovf, out_valid
  );

  modport slave (
    input  in_valid, x, y, ci,
    output s, co, ovf, out_valid
  );
endinterface

// File: rtl/rca_4bit_adder.sv
// Registered 4-bit ripple-carry adder: four full-adder cells feed a result
// register holding sum, carry-out and signed overflow, qualified by out_valid.
module rca_4bit_adder (
  input  logic             clk,
  input  logic             rst,
  rca_4bit_adder_if.slave  bus
);

  logic [4:0] carry;
  logic [3:0] sum_comb;
  logic       ovf_comb;

  assign carry[0] = bus.ci;

  // Explicit cell chain so the ripple structure matches the intended critical path.
  for (genvar i = 0; i < 4; i++) begin : g_fa
    logic prop;
    assign prop         = bus.x[i] ^ bus.y[i];
    assign sum_comb[i]  = prop ^ carry[i];
    assign carry[i + 1] = (bus.x[i] & bus.y[i]) | (carry[i] & prop);
  end

  // Carry into the sign bit disagreeing with carry out of it means signed overflow.
  assign ovf_comb = carry[4] ^ carry[3];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.s         <= 4'b0000;
      bus.co        <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.s   <= sum_comb;
        bus.co  <= carry[4];
        bus.ovf <= ovf_comb;
      end
    end
  end

endmodule

// File: tb/tb_rca_4bit_adder.sv
// Scoreboard bench for rca_4bit_adder: the driver queues one expected result
// per cycle it drives, and a monitor compares it one edge later.
module tb_rca_4bit_adder;

  typedef struct packed {
    logic       out_valid;
    logic       co;
    logic       ovf;
    logic [3:0] s;
  } result_t;

  logic clk;
  logic rst;
  rca_4bit_adder_if bus ();

  rca_4bit_adder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  result_t    exp_q[$];
  int         n_vec  = 0;
  int         n_fail = 0;
  logic [3:0] held_s;
  logic       held_co;
  logic       held_ovf;

  function automatic result_t observed();
    return '{out_valid: bus.out_valid, co: bus.co, ovf: bus.ovf, s: bus.s};
  endfunction

  task automatic check(input string name, input result_t act, input result_t req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got valid=%b co=%b ovf=%b s=%b, want valid=%b co=%b ovf=%b s=%b",
               name, act.out_valid, act.co, act.ovf, act.s,
               req.out_valid, req.co, req.ovf, req.s);
    end
  endtask

  // Drive one cycle of stimulus on the falling edge and queue what must
  // appear right after the following rising edge.
  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [3:0] es, input logic eco,
                       input logic eovf);
    @(negedge clk);
    bus.in_valid = v;
    bus.x        = a;
    bus.y        = b;
    bus.ci       = c;
    if (v) begin
      held_s   = es;
      held_co  = eco;
      held_ovf = eovf;
    end
    exp_q.push_back('{out_valid: v, co: held_co, ovf: held_ovf, s: held_s});
  endtask

  // Monitor: one comparison per rising edge while results are expected.
  initial begin
    result_t req;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (exp_q.size() > 0) begin
          req = exp_q.pop_front();
          check("pipeline", observed(), req);
        end else if (bus.out_valid) begin
          check("unexpected_valid", observed(), '0);
        end
      end
    end
  end

  initial begin
    logic [4:0] total;
    logic [3:0] xs;
    logic [3:0] ys;
    logic       cs;
    logic       vf;
    int         wait_cycles;

    held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.x        = 4'b1011;
    bus.y        = 4'b0110;
    bus.ci       = 1'b1;

    // Reset held across running edges with valid operands present.
    repeat (3) @(posedge clk);
    #1 check("reset_hold", observed(), '0);

    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    // Directed vectors with hand-computed results.
    drive(1'b1, 4'b0111, 4'b0010, 1'b0, 4'b1001, 1'b0, 1'b1);
    drive(1'b1, 4'b0110, 4'b1001, 1'b1, 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 4'b0011, 4'b0101, 1'b1, 4'b1001, 1'b0, 1'b1);
    drive(1'b0, 4'b1110, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b0, 4'b0101, 4'b1100, 1'b1, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);
    drive(1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    drive(1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    drive(1'b1, 4'b0101, 4'b0100, 1'b0, 4'b1001, 1'b0, 1'b1);

    // Mid-stream asynchronous reset while a valid result is on the outputs.
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1 check("reset_async", observed(), '0);
    held_s = '0; held_co = 1'b0; held_ovf = 1'b0;
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("reset_held_midstream", observed(), '0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;

    drive(1'b1, 4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
    drive(1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b0);

    // Exhaustive back-to-back sweep against arithmetic and sign rules.
    for (int i = 0; i < 512; i++) begin
      xs    = 4'(i >> 5);
      ys    = 4'(i >> 1);
      cs    = 1'(i);
      total = 5'(xs) + 5'(ys) + 5'(cs);
      vf    = (xs[3] == ys[3]) && (total[3] != xs[3]);
      drive(1'b1, xs, ys, cs, total[3:0], total[4], vf);
    end
    drive(1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
